serial_subtractor: RTL

Parametrised multi-cycle adder/subtractor built on the full-subtractor bit cell. It processes a WIDTH-bit operand pair DIGIT bits per clock, LSB first, and carries the borrow (or carry) in a register between cycles. A start/busy/done handshake frames each operation. It sits wherever a wide subtract or add is needed and area matters more than latency, trading cycles for a DIGIT-bit-wide datapath.

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; the requester drives start and
// operands, the datapath returns busy/done and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, mode, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, mode, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial add/subtract: DIGIT bits per clock, LSB first, with the
// borrow/carry held in a chain register between slices.
//
// state  | meaning
// IDLE   | waiting for start, results hold
// RUN    | one slice per clock, busy=1
// DONE   | one-cycle done pulse, results just loaded; start may relaunch
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_chain;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_load;
  logic             w_last;
  logic [DIGIT-1:0] w_d;
  logic             w_cin_msb;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_nxt;

  // A relaunch is legal from IDLE and from DONE; start is ignored in RUN.
  assign w_load = bus.start && (r_state != S_RUN);
  assign w_last = (r_state == S_RUN) && (r_cnt == LAST);

  // Ripple the current slice through DIGIT bit cells. Also exposes the chain
  // value entering the top cell of the slice, which on the last slice is the
  // chain into bit WIDTH-1 and feeds the overflow flag.
  always_comb begin
    logic c;
    logic x;
    logic y;
    c         = r_chain;
    w_d       = '0;
    w_cin_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      x         = r_a[i];
      y         = r_b[i];
      w_cin_msb = c;
      w_d[i]    = x ^ y ^ c;
      if (r_mode)
        c = (x & y) | ((x ^ y) & c);
      else
        c = (~x & y) | (~(x ^ y) & c);
    end
    w_cout = c;
  end

  // Slice results enter at the top and shift down, so after N slices the
  // first slice sits at bit 0.
  generate
    if (N == 1) begin : g_single
      assign w_acc_nxt = w_d;
    end else begin : g_multi
      assign w_acc_nxt = {w_d, r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_RUN:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and per-slice datapath advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_chain <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_mode  <= bus.mode;
      r_chain <= bus.bin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_nxt;
      r_chain <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result registers load only on the final slice and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_diff <= w_acc_nxt;
      r_bout <= w_cout;
      r_ovf  <= w_cin_msb ^ w_cout;
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;

endmodule
